// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: one round per clk_sys edge, external round-key supply.
// Expected busy window: round_num steps 1..10 with rkey_en=1, and cipher_ready returns 11 cycles after the start cycle.
module aes128_cipher_core (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [127:0] round_key_0,
    input  logic [127:0] round_key_in,
    input  logic [127:0] plain_text,
    input  logic         cipher_en,
    output logic [127:0] cipher_text,
    output logic         cipher_ready,
    output logic [3:0]   round_num,
    output logic         rkey_en
);

    logic [127:0] state_r;
    logic [3:0]   cnt_r;
    logic         ready_r;
    logic         rkey_en_r;
    logic         start_s;
    logic [127:0] sub_shift_s;
    logic [127:0] round_out_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] t;
        logic [7:0] r;
        t = b;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign start_s = cipher_en & ready_r;

    // Combinational round: the last round skips MixColumns.
    always_comb begin
        sub_shift_s = sub_shift_rows(state_r);
        round_out_s = state_r;
        if (cnt_r == 4'd10) begin
            round_out_s = sub_shift_s ^ round_key_in;
        end else begin
            round_out_s = mix_columns(sub_shift_s) ^ round_key_in;
        end
    end

    // Round sequencing and the state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            ready_r   <= 1'b1;
            rkey_en_r <= 1'b0;
            state_r   <= 128'h0;
        end else begin
            if (cnt_r == 4'd10) begin
                cnt_r <= 4'd0;
            end else if (start_s || rkey_en_r) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (start_s) begin
                ready_r   <= 1'b0;
                rkey_en_r <= 1'b1;
            end else if (cnt_r == 4'd10) begin
                ready_r   <= 1'b1;
                rkey_en_r <= 1'b0;
            end else begin
                ready_r   <= ready_r;
                rkey_en_r <= rkey_en_r;
            end

            if (start_s) begin
                state_r <= plain_text ^ round_key_0;
            end else if (rkey_en_r) begin
                state_r <= round_out_s;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign cipher_text  = state_r;
    assign cipher_ready = ready_r;
    assign round_num    = cnt_r;
    assign rkey_en      = rkey_en_r;

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Scoreboard bench for aes128_cipher_core with a byte-level AES reference model.
module tb_aes128_cipher_core;

    logic         clk_sys;
    logic         rst_n;
    logic [127:0] round_key_0;
    logic [127:0] round_key_in;
    logic [127:0] plain_text;
    logic         cipher_en;
    logic [127:0] cipher_text;
    logic         cipher_ready;
    logic [3:0]   round_num;
    logic         rkey_en;

    aes128_cipher_core dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .round_key_0 (round_key_0),
        .round_key_in(round_key_in),
        .plain_text  (plain_text),
        .cipher_en   (cipher_en),
        .cipher_text (cipher_text),
        .cipher_ready(cipher_ready),
        .round_num   (round_num),
        .rkey_en     (rkey_en)
    );

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] E0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int total = 0;
    int bad   = 0;
    logic [7:0]   sbox_t [256];
    logic [7:0]   inv_t  [256];
    logic [127:0] rk_cur [16];
    logic [127:0] exp_q [$];
    logic         prev_rdy = 1'b1;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always_comb begin
        round_key_in = 128'h0;
        if (round_num >= 4'd1 && round_num <= 4'd10) round_key_in = rk_cur[round_num];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, aa, bb;
        acc = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) acc = acc ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    // S-box table from walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k, input int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] subst(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_t[s[127-8*i -: 8]] : sbox_t[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (inv) o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
                else     o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    // Column times the circulant matrix whose first row is base.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] base);
        logic [127:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[31-8*((j-r+4)%4) -: 8], s[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key(k, 0);
        for (int rnd = 1; rnd <= 10; rnd++) begin
            s = shift(subst(s, 1'b0), 1'b0);
            if (rnd < 10) s = mix(s, 32'h02030101);
            s = s ^ round_key(k, rnd);
        end
        return s;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ round_key(k, 10);
        for (int rnd = 9; rnd >= 0; rnd--) begin
            s = subst(shift(s, 1'b1), 1'b1) ^ round_key(k, rnd);
            if (rnd > 0) s = mix(s, 32'h0e0b0d09);
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_block(input logic [127:0] k, input logic [127:0] pt);
        for (int i = 0; i <= 10; i++) rk_cur[i] = round_key(k, i);
        round_key_0 = k;
        plain_text  = pt;
        cipher_en   = 1'b1;
        exp_q.push_back(model_encrypt(k, pt));
        @(negedge clk_sys);
        cipher_en = 1'b0;
    endtask

    // Waits for ready with ignored cipher_en pulses; returns cycles since the start cycle.
    task automatic wait_ready(input bit noisy, output int n);
        n = 1;
        while (!cipher_ready && n < 30) begin
            cipher_en  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            plain_text = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk_sys);
            n++;
        end
        cipher_en = 1'b0;
        if (!cipher_ready) chk("ready_timeout", 128'(n), 128'd11);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_sys) begin
        logic [127:0] e;
        if (!rst_n) begin
            prev_rdy = 1'b1;
        end else begin
            if (cipher_ready && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("scb_unexpected", cipher_text, 128'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("scb_ct", cipher_text, e);
                end
            end
            prev_rdy = cipher_ready;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [127:0] k, p;
        build_sbox();
        for (int i = 0; i < 16; i++) rk_cur[i] = 128'h0;
        rst_n = 1'b0; cipher_en = 1'b0; round_key_0 = 128'h0; plain_text = 128'h0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("reset_ct", cipher_text, 128'h0);
        chk("reset_ctl", {122'h0, cipher_ready, rkey_en, round_num}, {122'h0, 1'b1, 1'b0, 4'd0});
        rst_n = 1'b1;
        @(negedge clk_sys);

        // App. B with control trace and an ignored start at round 5
        start_block(KEY_B, PT_B);
        chk("appB_e0", cipher_text, E0_B);
        for (int i = 1; i <= 10; i++) begin
            chk("ctl_busy", {122'h0, cipher_ready, rkey_en, round_num}, {122'h0, 1'b0, 1'b1, 4'(i)});
            cipher_en  = (i == 5);
            plain_text = (i == 5) ? PT_C : PT_B;
            @(negedge clk_sys);
        end
        cipher_en = 1'b0;
        chk("ctl_done", {122'h0, cipher_ready, rkey_en, round_num}, {122'h0, 1'b1, 1'b0, 4'd0});
        chk("appB_ct", cipher_text, CT_B);

        // Back-to-back App. C.1 in the first ready cycle
        start_block(KEY_C, PT_C);
        wait_ready(1'b0, n);
        chk("b2b_latency", 128'(n), 128'd11);
        chk("appC_ct", cipher_text, CT_C);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("hold_ct", cipher_text, CT_C);

        // Randomized blocks with ignored mid-flight starts
        for (int b = 0; b < 6; b++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_block(k, p);
            wait_ready(1'b1, n);
            chk("rand_latency", 128'(n), 128'd11);
        end

        // Reset during round 6, then a fresh App. B run
        start_block(KEY_B, PT_B);
        repeat (5) @(negedge clk_sys);
        chk("pre_abort_round", {124'h0, round_num}, {124'h0, 4'd6});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ct", cipher_text, 128'h0);
        chk("abort_ctl", {122'h0, cipher_ready, rkey_en, round_num}, {122'h0, 1'b1, 1'b0, 4'd0});
        exp_q.delete();
        @(negedge clk_sys);
        #2 rst_n = 1'b1;
        @(negedge clk_sys);
        start_block(KEY_B, PT_B);
        wait_ready(1'b0, n);
        chk("post_abort_latency", 128'(n), 128'd11);
        chk("post_abort_ct", cipher_text, CT_B);
        chk("loopback_pt", model_decrypt(KEY_B, cipher_text), PT_B);

        @(negedge clk_sys);
        chk("scb_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
